// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking
// and minus-sign placement for the 7-segment display mux.
module bcd_display_formatter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value_i,
  input  logic                  neg_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic [DIGITS-1:0]     minus_o,
  output logic                  sign_ovf_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    snap_value_q;
  logic                snap_neg_q;
  logic [WIDTH-1:0]    shift_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic [CW-1:0]       count_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   minus_q;
  logic                sign_ovf_q;
  logic                busy_q;
  logic                done_q;

  logic [4*DIGITS-1:0] adj_d;
  logic [4*DIGITS-1:0] scratch_d;
  logic [DIGITS-1:0]   blank_d;
  logic [DIGITS-1:0]   minus_d;
  logic                sign_ovf_d;
  logic                zero_above;
  int                  msd;

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_d = (adj_d << 1) | {{(4*DIGITS-1){1'b0}}, shift_q[WIDTH-1]};
  end

  // Unblanked digits are contiguous from digit 0, so the highest one is the MSD.
  always_comb begin
    zero_above = 1'b1;
    blank_d    = '0;
    minus_d    = '0;
    msd        = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (scratch_q[4*i +: 4] == 4'd0);
      blank_d[i] = (i > 0) && zero_above;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (!blank_d[i]) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      minus_d[i] = snap_neg_q && (i == msd + 1);
    end
    sign_ovf_d = snap_neg_q && (msd == DIGITS - 1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_value_q <= '0;
      snap_neg_q   <= 1'b0;
      shift_q      <= '0;
      scratch_q    <= '0;
      count_q      <= '0;
      bcd_q        <= '0;
      blank_q      <= {{(DIGITS-1){1'b1}}, 1'b0};
      minus_q      <= '0;
      sign_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ({neg_i, value_i} != {snap_neg_q, snap_value_q}) begin
            snap_value_q <= value_i;
            snap_neg_q   <= neg_i;
            shift_q      <= value_i;
            scratch_q    <= '0;
            count_q      <= CW'(WIDTH);
            busy_q       <= 1'b1;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
          count_q   <= count_q - 1'b1;
          if (count_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          bcd_q      <= scratch_q;
          blank_q    <= blank_d;
          minus_q    <= minus_d;
          sign_ovf_q <= sign_ovf_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_o      = bcd_q;
  assign blank_o    = blank_q;
  assign minus_o    = minus_q;
  assign sign_ovf_o = sign_ovf_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
